map_blitter: RTL and testbench

//  Fill/copy engine for the 32x32 tile map RAM. It shares map_ram port B between the CPU and an internal engine.

---
 rtl/map_blitter_pkg.sv | 42 ++++
 rtl/map_port_mux.sv | 57 +++++
 rtl/map_blitter.sv | 227 ++++++++++++++++++++++
 tb/tb_map_blitter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_blitter_pkg.sv
// map_blitter_pkg
//   Shared definitions for the tile-map fill/copy engine: FSM state
//   encoding, CTRL/STATUS register bit positions, the LEN ceiling and a
//   helper that assembles the STATUS word.
//   Optional feature macro used by map_blitter: MAP_BLITTER_ABORT_EN.
package map_blitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_C_READ,
      ST_C_CAPT,
      ST_C_WRITE
   } state_t;

   // CTRL write fields
   localparam int CTRL_START    = 0;
   localparam int CTRL_MODE     = 1;   // 0 fill, 1 copy
   localparam int CTRL_ABORT    = 2;
   localparam int CTRL_FILL_LSB = 24;

   // STATUS read fields
   localparam int STAT_BUSY     = 31;
   localparam int STAT_DONE     = 30;
   localparam int STAT_ABORTED  = 29;

   // Largest element count: the whole 32x32 map
   localparam int LEN_MAX       = 1024;

   function automatic logic [31:0] status_word(input logic        busy,
                                               input logic        done,
                                               input logic        aborted,
                                               input logic [31:0] remaining);
      logic [31:0] w;
      w               = remaining;
      w[STAT_BUSY]    = busy;
      w[STAT_DONE]    = done;
      w[STAT_ABORTED] = aborted;
      return w;
   endfunction

endpackage

// File: rtl/map_port_mux.sv
// map_port_mux
//   CPU-priority multiplexer for map_ram port B. When the CPU selects the
//   map window it owns the port outright; otherwise the engine request is
//   forwarded and grant tells the engine its access actually happened.
// Ports
//   cpu_*   : CPU map window access (select, strobes, row/col, write data)
//   eng_*   : engine request (select, strobes, row/col, write data)
//   b_*     : to map_ram port B
//   grant   : 1 when the engine owns the port this cycle
module map_port_mux
   import map_blitter_pkg::*;
#(
   parameter int HALF_W = 5,
   parameter int TILE_W = 8
) (
   input  logic              cpu_map_cs,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [HALF_W-1:0] cpu_row,
   input  logic [HALF_W-1:0] cpu_col,
   input  logic [TILE_W-1:0] cpu_data,
   input  logic              eng_cs,
   input  logic              eng_read,
   input  logic              eng_write,
   input  logic [HALF_W-1:0] eng_row,
   input  logic [HALF_W-1:0] eng_col,
   input  logic [TILE_W-1:0] eng_data,
   output logic              b_cs,
   output logic              b_read,
   output logic              b_write,
   output logic [HALF_W-1:0] b_row,
   output logic [HALF_W-1:0] b_col,
   output logic [TILE_W-1:0] b_in,
   output logic              grant
);

   always_comb begin
      if (cpu_map_cs) begin
         b_cs    = 1'b1;
         b_read  = cpu_read;
         b_write = cpu_write;
         b_row   = cpu_row;
         b_col   = cpu_col;
         b_in    = cpu_data;
         grant   = 1'b0;
      end else begin
         b_cs    = eng_cs;
         b_read  = eng_read;
         b_write = eng_write;
         b_row   = eng_row;
         b_col   = eng_col;
         b_in    = eng_data;
         grant   = 1'b1;
      end
   end

endmodule

// File: rtl/map_blitter.sv
// map_blitter
//   Fill/copy engine for the 32x32 tile map RAM. Shares map_ram port B with
//   the CPU; CPU map accesses always win and the engine simply stalls.
//   Fill writes one element per granted cycle; copy uses read / capture /
//   write (three cycles per element uncontended).
//   Optional: MAP_BLITTER_ABORT_EN enables CTRL[2] abort and STATUS[29].
// Ports
//   clock, n_reset         : clock, async active-low reset
//   read, write            : CPU bus strobes
//   src_cs/dst_cs/len_cs   : register selects (index in data_in[11:2], LEN in [10:0])
//   ctrl_cs                : CTRL write / STATUS read
//   data_in, data_out(_valid) : CPU data; STATUS = {busy, done, aborted, 0, remaining}
//   cpu_map_cs/row/col/map_in : CPU map window access
//   b_*                    : map_ram port B (b_out registered, valid the cycle after a read)
//   busy, irq              : engine active, sticky DONE
module map_blitter
   import map_blitter_pkg::*;
#(
   parameter int INDEX_WIDTH = 10,
   parameter int TILE_WIDTH  = 8
) (
   input  logic                       clock,
   input  logic                       n_reset,
   input  logic                       read,
   input  logic                       write,
   input  logic                       src_cs,
   input  logic                       dst_cs,
   input  logic                       len_cs,
   input  logic                       ctrl_cs,
   input  logic [31:0]                data_in,
   output logic [31:0]                data_out,
   output logic                       data_out_valid,
   input  logic                       cpu_map_cs,
   input  logic [INDEX_WIDTH/2-1:0]   cpu_row,
   input  logic [INDEX_WIDTH/2-1:0]   cpu_col,
   input  logic [TILE_WIDTH-1:0]      cpu_map_in,
   output logic                       b_cs,
   output logic                       b_read,
   output logic                       b_write,
   output logic [INDEX_WIDTH/2-1:0]   b_row,
   output logic [INDEX_WIDTH/2-1:0]   b_col,
   output logic [TILE_WIDTH-1:0]      b_in,
   input  logic [TILE_WIDTH-1:0]      b_out,
   output logic                       busy,
   output logic                       irq
);

   localparam int HALF_W    = INDEX_WIDTH / 2;
   localparam int LEN_W     = INDEX_WIDTH + 1;
   localparam int LEN_MAX_P = 1 << INDEX_WIDTH;

   state_t                 state;
   logic [INDEX_WIDTH-1:0] src;
   logic [INDEX_WIDTH-1:0] dst;
   logic [LEN_W-1:0]       remaining;
   logic [LEN_W-1:0]       len_wr;
   logic [TILE_WIDTH-1:0]  fill_val;
   logic [TILE_WIDTH-1:0]  copy_buf;
   logic                   done;
   logic                   aborted;

   logic                   status_rd;
   logic                   reg_wr;
   logic                   start_req;
   logic                   abort_req;
   logic                   grant;
   logic                   step;
   logic                   last_step;
   logic                   done_set;

   logic                   eng_cs;
   logic                   eng_read;
   logic                   eng_write;
   logic [INDEX_WIDTH-1:0] eng_idx;
   logic [TILE_WIDTH-1:0]  eng_data;

   // Only some data_in bits are register fields.
   logic                   unused_data;
   assign unused_data = ^data_in;

   assign busy           = (state != ST_IDLE);
   assign irq            = done;
   assign status_rd      = ctrl_cs && read;
   assign data_out_valid = status_rd;
   assign reg_wr         = write && !busy;
   assign start_req      = reg_wr && ctrl_cs && data_in[CTRL_START];

   // LEN values above a full map are clamped rather than truncated.
   assign len_wr = (data_in[LEN_W-1:0] > LEN_W'(LEN_MAX_P)) ? LEN_W'(LEN_MAX_P)
                                                           : data_in[LEN_W-1:0];

`ifdef MAP_BLITTER_ABORT_EN
   assign abort_req = write && ctrl_cs && busy && data_in[CTRL_ABORT];

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset)       aborted <= 1'b0;
      else if (abort_req) aborted <= 1'b1;
      else if (status_rd) aborted <= 1'b0;
   end
`else
   assign abort_req = 1'b0;
   assign aborted   = 1'b0;
`endif

   // Engine port request. An aborting cycle drops the request so the
   // element being worked on is left untouched.
   always_comb begin
      eng_cs    = 1'b0;
      eng_read  = 1'b0;
      eng_write = 1'b0;
      eng_idx   = dst;
      eng_data  = fill_val;
      if (!abort_req) begin
         case (state)
            ST_FILL: begin
               eng_cs    = 1'b1;
               eng_write = 1'b1;
            end
            ST_C_READ: begin
               eng_cs   = 1'b1;
               eng_read = 1'b1;
               eng_idx  = src;
            end
            ST_C_WRITE: begin
               eng_cs    = 1'b1;
               eng_write = 1'b1;
               eng_data  = copy_buf;
            end
            default: ;
         endcase
      end
   end

   map_port_mux #(
      .HALF_W (HALF_W),
      .TILE_W (TILE_WIDTH)
   ) u_mux (
      .cpu_map_cs (cpu_map_cs),
      .cpu_read   (read),
      .cpu_write  (write),
      .cpu_row    (cpu_row),
      .cpu_col    (cpu_col),
      .cpu_data   (cpu_map_in),
      .eng_cs     (eng_cs),
      .eng_read   (eng_read),
      .eng_write  (eng_write),
      .eng_row    (eng_idx[INDEX_WIDTH-1:HALF_W]),
      .eng_col    (eng_idx[HALF_W-1:0]),
      .eng_data   (eng_data),
      .b_cs       (b_cs),
      .b_read     (b_read),
      .b_write    (b_write),
      .b_row      (b_row),
      .b_col      (b_col),
      .b_in       (b_in),
      .grant      (grant)
   );

   assign step      = grant && !abort_req;
   assign last_step = step && (remaining == LEN_W'(1)) &&
                      (state == ST_FILL || state == ST_C_WRITE);
   assign done_set  = (start_req && remaining == '0) || last_step;

   always_comb begin
      data_out = '0;
      if (status_rd)
         data_out = status_word(busy, done, aborted, 32'(remaining));
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state     <= ST_IDLE;
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
         fill_val  <= '0;
         copy_buf  <= '0;
         done      <= 1'b0;
      end else begin
         // Set wins over the read-clear in the same cycle.
         if (done_set)       done <= 1'b1;
         else if (status_rd) done <= 1'b0;

         if (reg_wr) begin
            if (src_cs) src       <= data_in[INDEX_WIDTH+1:2];
            if (dst_cs) dst       <= data_in[INDEX_WIDTH+1:2];
            if (len_cs) remaining <= len_wr;
         end

         case (state)
            ST_IDLE: begin
               if (start_req && remaining != '0) begin
                  fill_val <= data_in[CTRL_FILL_LSB +: TILE_WIDTH];
                  state    <= data_in[CTRL_MODE] ? ST_C_READ : ST_FILL;
               end
            end
            ST_FILL: begin
               if (step) begin
                  dst       <= dst + INDEX_WIDTH'(1);
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) state <= ST_IDLE;
               end
            end
            ST_C_READ: begin
               if (step) state <= ST_C_CAPT;
            end
            ST_C_CAPT: begin
               // b_out holds the word read on the previous granted cycle.
               copy_buf <= b_out;
               state    <= ST_C_WRITE;
            end
            ST_C_WRITE: begin
               if (step) begin
                  src       <= src + INDEX_WIDTH'(1);
                  dst       <= dst + INDEX_WIDTH'(1);
                  remaining <= remaining - LEN_W'(1);
                  state     <= (remaining == LEN_W'(1)) ? ST_IDLE : ST_C_READ;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (abort_req) state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_map_blitter.sv
module tb_map_blitter;

   logic        clock = 1'b0;
   logic        n_reset = 1'b0;
   logic        read = 1'b0, write = 1'b0;
   logic        src_cs = 1'b0, dst_cs = 1'b0, len_cs = 1'b0, ctrl_cs = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        data_out_valid;
   logic        cpu_map_cs = 1'b0;
   logic [4:0]  cpu_row = '0, cpu_col = '0;
   logic [7:0]  cpu_map_in = '0;
   logic        b_cs, b_read, b_write;
   logic [4:0]  b_row, b_col;
   logic [7:0]  b_in;
   logic [7:0]  b_out;
   logic        busy, irq;

   int n_chk  = 0;
   int n_fail = 0;

   localparam int R_SRC = 0, R_DST = 1, R_LEN = 2, R_CTRL = 3;

   always #5 clock = ~clock;

   map_blitter dut (
      .clock(clock), .n_reset(n_reset), .read(read), .write(write),
      .src_cs(src_cs), .dst_cs(dst_cs), .len_cs(len_cs), .ctrl_cs(ctrl_cs),
      .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
      .cpu_map_cs(cpu_map_cs), .cpu_row(cpu_row), .cpu_col(cpu_col),
      .cpu_map_in(cpu_map_in), .b_cs(b_cs), .b_read(b_read), .b_write(b_write),
      .b_row(b_row), .b_col(b_col), .b_in(b_in), .b_out(b_out),
      .busy(busy), .irq(irq)
   );

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   // map_ram port B model
   logic [7:0] mem [0:1023];
   logic       init_mem = 1'b0;
   always @(posedge clock) begin
      if (init_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else if (b_cs) begin
         if (b_write) mem[{b_row, b_col}] <= b_in;
         if (b_read)  b_out <= mem[{b_row, b_col}];
      end
   end

   // Reference map contents and the engine writes they imply, in order
   logic [7:0] ref_mem [0:1023];
   typedef struct { int idx; logic [7:0] data; } wr_t;
   wr_t exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Per-cycle checks: port arbitration, data_out_valid, engine write stream
   always @(negedge clock) begin : compare
      wr_t e;
      check("dout_valid", 32'(data_out_valid), 32'(ctrl_cs && read));
      if (cpu_map_cs) begin
         check("port_cpu", 32'({b_cs, b_read, b_write, b_row, b_col, b_in}),
               32'({1'b1, read, write, cpu_row, cpu_col, cpu_map_in}));
      end else if (!busy) begin
         check("port_idle_cs", 32'(b_cs), 32'(0));
      end else if (b_cs && b_write) begin
         if (exp_q.size() == 0) begin
            check("eng_wr_unexpected", 32'({b_row, b_col}), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("eng_wr_idx", 32'({b_row, b_col}), 32'(e.idx));
            check("eng_wr_data", 32'(b_in), 32'(e.data));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic reg_wr(input int sel, input logic [31:0] d);
      write = 1'b1; data_in = d;
      src_cs = (sel == R_SRC); dst_cs = (sel == R_DST);
      len_cs = (sel == R_LEN); ctrl_cs = (sel == R_CTRL);
      tick();
      write = 1'b0; data_in = '0;
      src_cs = 1'b0; dst_cs = 1'b0; len_cs = 1'b0; ctrl_cs = 1'b0;
   endtask

   task automatic status_chk(input string name, input logic [31:0] exp);
      read = 1'b1; ctrl_cs = 1'b1;
      @(negedge clock);
      check(name, data_out, exp);
      tick();
      read = 1'b0; ctrl_cs = 1'b0;
   endtask

   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (busy && cyc < 3000) begin
         tick();
         cyc++;
      end
   endtask

   task automatic plan_fill(input int dst, input int len, input logic [7:0] v);
      for (int i = 0; i < len; i++) begin
         int d;
         d = (dst + i) % 1024;
         ref_mem[d] = v;
         exp_q.push_back('{idx: d, data: v});
      end
   endtask

   task automatic plan_copy(input int src, input int dst, input int len);
      for (int i = 0; i < len; i++) begin
         int s, d;
         s = (src + i) % 1024;
         d = (dst + i) % 1024;
         ref_mem[d] = ref_mem[s];
         exp_q.push_back('{idx: d, data: ref_mem[d]});
      end
   endtask

   task automatic check_mem(input string name, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         int a;
         a = (lo + i) % 1024;
         check(name, 32'(mem[a]), 32'(ref_mem[a]));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

      // Reset and map initialisation
      init_mem = 1'b1;
      repeat (2) tick();
      init_mem = 1'b0;
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_irq", 32'(irq), 32'(0));
      check("rst_dout", data_out, 32'h0);
      n_reset = 1'b1;
      tick();
      status_chk("rst_status", 32'h0);

      // 1: fill across the 1023->0 wrap
      reg_wr(R_DST, 32'(32'h3E0 << 2));
      reg_wr(R_LEN, 32'd64);
      plan_fill(32'h3E0, 64, 8'h2A);
      reg_wr(R_CTRL, 32'h2A00_0001);
      wait_idle(cyc);
      check("fill_cycles", 32'(cyc), 32'd64);
      check("fill_irq", 32'(irq), 32'(1));
      check("fill_q_empty", 32'(exp_q.size()), 32'(0));
      check_mem("fill_mem", 32'h3C0, 128);
      check("fill_lit_3e0", 32'(mem[32'h3E0]), 32'h2A);
      check("fill_lit_01f", 32'(mem[32'h01F]), 32'h2A);
      check("fill_lit_020", 32'(mem[32'h020]), 32'hE3);
      check("fill_lit_3df", 32'(mem[32'h3DF]), 32'h1C);
      status_chk("fill_status", 32'h4000_0000);

      // 2: copy 0..3 -> 0x100..0x103
      reg_wr(R_SRC, 32'h0);
      reg_wr(R_DST, 32'(32'h100 << 2));
      reg_wr(R_LEN, 32'd4);
      plan_copy(0, 32'h100, 4);
      reg_wr(R_CTRL, 32'h0000_0003);
      wait_idle(cyc);
      check("copy_cycles", 32'(cyc), 32'd12);
      check("copy_irq", 32'(irq), 32'(1));
      check_mem("copy_mem", 32'h0FC, 12);
      check("copy_lit_103", 32'(mem[32'h103]), 32'h2A);
      check("copy_lit_104", 32'(mem[32'h104]), 32'h1F);
      status_chk("copy_status", 32'h4000_0000);

      // 3: CPU map writes every other cycle during a fill
      reg_wr(R_DST, 32'(32'h300 << 2));
      reg_wr(R_LEN, 32'd8);
      plan_fill(32'h300, 8, 8'h3C);
      reg_wr(R_CTRL, 32'h3C00_0001);
      cyc = 0;
      while (busy && cyc < 200) begin
         if (cyc % 2 == 0) begin
            int a;
            a = 32'h200 + cyc / 2;
            cpu_map_cs = 1'b1; write = 1'b1;
            {cpu_row, cpu_col} = 10'(a);
            cpu_map_in = 8'(192 + cyc / 2);
            ref_mem[a] = cpu_map_in;
         end else begin
            cpu_map_cs = 1'b0; write = 1'b0;
         end
         tick();
         cyc++;
      end
      cpu_map_cs = 1'b0; write = 1'b0;
      check("cont_cycles", 32'(cyc), 32'd16);
      check_mem("cont_cpu_mem", 32'h200, 8);
      check_mem("cont_fill_mem", 32'h2F8, 24);
      check("cont_lit_203", 32'(mem[32'h203]), 32'hC3);
      check("cont_lit_307", 32'(mem[32'h307]), 32'h3C);
      status_chk("cont_status", 32'h4000_0000);

      // 4: LEN=0 start
      check("len0_irq_before", 32'(irq), 32'(0));
      reg_wr(R_LEN, 32'd0);
      reg_wr(R_CTRL, 32'h0000_0001);
      check("len0_irq", 32'(irq), 32'(1));
      check("len0_busy0", 32'(busy), 32'(0));
      tick();
      check("len0_busy1", 32'(busy), 32'(0));
      status_chk("len0_status1", 32'h4000_0000);
      status_chk("len0_status2", 32'h0000_0000);

      // 5a: register writes while busy are ignored
      reg_wr(R_SRC, 32'(32'h10 << 2));
      reg_wr(R_DST, 32'(32'h20 << 2));
      reg_wr(R_LEN, 32'd6);
      plan_copy(32'h10, 32'h20, 6);
      reg_wr(R_CTRL, 32'h0000_0003);
      cyc = 0;
      while (busy && cyc < 200) begin
         write   = (cyc >= 2 && cyc <= 4);
         len_cs  = (cyc == 2);
         ctrl_cs = (cyc == 3);
         src_cs  = (cyc == 4);
         data_in = (cyc == 2) ? 32'd1 : (cyc == 3) ? 32'h5500_0001 :
                   (cyc == 4) ? 32'h0000_0FFC : 32'h0;
         tick();
         cyc++;
      end
      write = 1'b0; len_cs = 1'b0; ctrl_cs = 1'b0; src_cs = 1'b0; data_in = '0;
      check("busywr_cycles", 32'(cyc), 32'd18);
      check_mem("busywr_mem", 32'h1E, 10);
      check("busywr_lit_25", 32'(mem[32'h25]), 32'h2A);
      check("busywr_lit_26", 32'(mem[32'h26]), 32'h0D);
      check("busywr_irq", 32'(irq), 32'(1));

      // 5b: reset pulse mid-copy (DONE still set from 5a)
      reg_wr(R_SRC, 32'(32'h40 << 2));
      reg_wr(R_DST, 32'(32'h60 << 2));
      reg_wr(R_LEN, 32'd8);
      plan_copy(32'h40, 32'h60, 8);
      reg_wr(R_CTRL, 32'h0000_0003);
      repeat (5) tick();
      check("midrst_busy_before", 32'(busy), 32'(1));
      n_reset = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_irq", 32'(irq), 32'(0));
      tick();
      n_reset = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
      check("midrst_lit_60", 32'(mem[32'h60]), 32'hC3);
      check("midrst_lit_61", 32'(mem[32'h61]), 32'hAA);
      tick();
      status_chk("midrst_status", 32'h0);
      // DST and SRC back at 0
      reg_wr(R_LEN, 32'd2);
      plan_fill(0, 2, 8'h77);
      reg_wr(R_CTRL, 32'h7700_0001);
      wait_idle(cyc);
      check("rstdst_cycles", 32'(cyc), 32'd2);
      check("rstdst_lit_001", 32'(mem[1]), 32'h77);
      reg_wr(R_DST, 32'(32'h180 << 2));
      reg_wr(R_LEN, 32'd1);
      plan_copy(0, 32'h180, 1);
      reg_wr(R_CTRL, 32'h0000_0003);
      wait_idle(cyc);
      check("rstsrc_cycles", 32'(cyc), 32'd3);
      check("rstsrc_lit_180", 32'(mem[32'h180]), 32'h77);
      status_chk("rstsrc_status", 32'h4000_0000);

`ifdef MAP_BLITTER_ABORT_EN
      // 6: abort at element 3 of a 10-element fill
      reg_wr(R_DST, 32'(32'h50 << 2));
      reg_wr(R_LEN, 32'd10);
      plan_fill(32'h50, 3, 8'h99);
      reg_wr(R_CTRL, 32'h9900_0001);
      cyc = 0;
      while (busy && cyc < 200) begin
         write   = (cyc == 3);
         ctrl_cs = (cyc == 3);
         data_in = (cyc == 3) ? 32'h0000_0004 : 32'h0;
         tick();
         cyc++;
      end
      write = 1'b0; ctrl_cs = 1'b0; data_in = '0;
      check("abort_cycles", 32'(cyc), 32'd4);
      check("abort_irq", 32'(irq), 32'(0));
      check_mem("abort_mem", 32'h50, 10);
      check("abort_lit_52", 32'(mem[32'h52]), 32'h99);
      check("abort_lit_53", 32'(mem[32'h53]), 32'h48);
      status_chk("abort_status1", 32'h2000_0007);
      status_chk("abort_status2", 32'h0000_0007);
`endif

      tick();
      check("final_q_empty", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
